sram_ctrl: RTL and testbench

- Responder side of the processor's SRAM access path.
- Accepts single-word read/write requests from the control FSM (instruction fetch, LW, SW) through a req/ready/done handshake.
- Sequences the external asynchronous 16-bit SRAM pins with registered, glitch-free strobes and programmable wait states.
- Sits between the control FSM and the board SRAM (256K x 16).

---
 rtl/sram_pkg.sv | 23 ++
 rtl/sram_wait_cnt.sv | 27 ++
 rtl/sram_ctrl.sv | 115 +++++++++++
 tb/tb_sram_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and defaults for the asynchronous SRAM access controller.
package sram_pkg;

    localparam int DATA_W      = 16;
    localparam int DEF_ADDR_W  = 18;
    localparam int DEF_RD_WAIT = 1;
    localparam int DEF_WR_WAIT = 1;

    typedef enum logic [2:0] {
        IDLE,
        RD_ACC,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_t;

    function automatic int cnt_width(input int rd, input int wr);
        int m;
        m = (rd > wr) ? rd : wr;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sram_wait_cnt.sv
// Loadable saturating down-counter used to time strobe widths.
module sram_wait_cnt #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sram_ctrl.sv
// Single-word read/write sequencer for a 16-bit asynchronous SRAM with
// registered strobes and programmable wait states.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int RD_WAIT = DEF_RD_WAIT,
    parameter int WR_WAIT = DEF_WR_WAIT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_in,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    localparam int CNT_W = cnt_width(RD_WAIT, WR_WAIT);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT - 1);

    state_t           state;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt_load_val;

    assign ready        = (state == IDLE);
    assign cnt_load     = ready && req;
    assign cnt_load_val = we ? WR_LOAD : RD_LOAD;
    // Write count is loaded at accept and held through the setup cycle.
    assign cnt_dec      = (state == RD_ACC) || (state == WR_PULSE);

    sram_wait_cnt #(
        .W        (CNT_W)
    ) u_wait_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
            sram_dq_oe  <= 1'b0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            rdata       <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req) begin
                        sram_addr <= addr;
                        sram_ce_n <= 1'b0;
                        if (we) begin
                            sram_dq_out <= wdata;
                            sram_dq_oe  <= 1'b1;
                            state       <= WR_SETUP;
                        end else begin
                            sram_oe_n <= 1'b0;
                            state     <= RD_ACC;
                        end
                    end
                end
                RD_ACC: begin
                    if (cnt_zero) begin
                        rdata     <= sram_dq_in;
                        done      <= 1'b1;
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        state     <= IDLE;
                    end
                end
                WR_SETUP: begin
                    sram_we_n <= 1'b0;
                    state     <= WR_PULSE;
                end
                WR_PULSE: begin
                    if (cnt_zero) begin
                        sram_we_n <= 1'b1;
                        state     <= WR_HOLD;
                    end
                end
                WR_HOLD: begin
                    done       <= 1'b1;
                    sram_dq_oe <= 1'b0;
                    sram_ce_n  <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl with a behavioural SRAM model.
module tb_sram_ctrl;
    import sram_pkg::*;

    localparam int AW  = 18;
    localparam int RDW = 2;
    localparam int WRW = 1;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic          req     = 1'b0;
    logic          we      = 1'b0;
    logic [AW-1:0] addr    = '0;
    logic [15:0]   wdata   = '0;
    logic          ready;
    logic          done;
    logic [15:0]   rdata;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_out;
    logic [15:0]   sram_dq_in;
    logic          sram_dq_oe;
    logic          ce_n;
    logic          oe_n;
    logic          we_n;

    logic [15:0]   mem [256];
    logic [255:0]  vld = '0;

    int vectors  = 0;
    int errors   = 0;
    int edge_cnt = 0;

    typedef struct {
        logic        is_rd;
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    sram_ctrl #(
        .ADDR_W      (AW),
        .RD_WAIT     (RDW),
        .WR_WAIT     (WRW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .ready       (ready),
        .done        (done),
        .rdata       (rdata),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_ce_n   (ce_n),
        .sram_oe_n   (oe_n),
        .sram_we_n   (we_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Asynchronous SRAM: latches data while we_n is low, drives DQ on oe_n.
    always @(posedge clk) begin
        if (!we_n && !ce_n) begin
            mem[sram_addr[7:0]] <= sram_dq_out;
            vld[sram_addr[7:0]] <= 1'b1;
        end
    end

    assign sram_dq_in = (!ce_n && !oe_n && vld[sram_addr[7:0]])
                        ? mem[sram_addr[7:0]] : 16'h0000;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)",
                     name, act, exp, edge_cnt);
        end
    endtask

    int            wl  = 0;
    int            ol  = 0;
    logic          pwe = 1'b1;
    logic [AW-1:0] pa  = '0;
    logic [15:0]   pd  = '0;

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got done=1, expected none (edge %0d)",
                         edge_cnt);
            end else begin
                mon_e = sb.pop_front();
                check("done_edge", edge_cnt, mon_e.due);
                check("ready_with_done", {31'd0, ready}, 32'd1);
                if (mon_e.is_rd) check("rdata", {16'd0, rdata}, {16'd0, mon_e.data});
            end
        end
        if (sram_dq_oe && !oe_n) begin
            errors++;
            $display("FAIL inv_dq_oe_vs_oe_n: got dq_oe=1 oe_n=0, expected oe_n=1");
        end
        if (!we_n && (!sram_dq_oe || ce_n)) begin
            errors++;
            $display("FAIL inv_we_n: got dq_oe=%b ce_n=%b, expected 1/0",
                     sram_dq_oe, ce_n);
        end
        if (!we_n && !pwe && (sram_addr !== pa || sram_dq_out !== pd)) begin
            errors++;
            $display("FAIL inv_stable: got %0h/%0h, expected %0h/%0h",
                     sram_addr, sram_dq_out, pa, pd);
        end
        pwe = we_n;
        pa  = sram_addr;
        pd  = sram_dq_out;
        if (!we_n) wl++;
        else if (wl != 0) begin
            check("we_pulse_len", wl, WRW);
            wl = 0;
        end
        if (!oe_n) ol++;
        else if (ol != 0) begin
            check("oe_low_len", ol, RDW);
            ol = 0;
        end
    end

    task automatic issue(input logic w, input logic [AW-1:0] a,
                         input logic [15:0] d, input logic [15:0] exp_rd,
                         input bit b2b);
        int guard;
        guard = 0;
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        while (!ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!ready) begin
            errors++;
            $display("FAIL ready_timeout: got ready=0, expected 1 within 50 cycles");
        end else begin
            exp_t e;
            e.is_rd = !w;
            e.data  = exp_rd;
            e.due   = edge_cnt + 1 + (w ? WRW + 2 : RDW);
            sb.push_back(e);
            if (b2b) check("b2b_in_done_cycle", {31'd0, done}, 32'd1);
        end
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100us");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        check("rst_ce_n", {31'd0, ce_n}, 32'd1);
        check("rst_oe_n", {31'd0, oe_n}, 32'd1);
        check("rst_we_n", {31'd0, we_n}, 32'd1);
        check("rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_addr", {14'd0, sram_addr}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {31'd0, ready}, 32'd1);

        issue(1'b1, 18'h00012, 16'hBEEF, 16'h0000, 1'b0);
        issue(1'b0, 18'h00012, 16'h0000, 16'hBEEF, 1'b1);
        issue(1'b0, 18'h00012, 16'h0000, 16'hBEEF, 1'b1);
        issue(1'b1, 18'h3FFFF, 16'h5A5A, 16'h0000, 1'b1);
        issue(1'b0, 18'h3FFFF, 16'h0000, 16'h5A5A, 1'b1);
        issue(1'b1, 18'h00055, 16'h1234, 16'h0000, 1'b1);

        // Stray read request while the write strobe is active.
        @(negedge clk);
        check("busy_in_pulse", {31'd0, ready}, 32'd0);
        req  = 1'b1;
        we   = 1'b0;
        addr = 18'h00099;
        @(negedge clk);
        req  = 1'b0;
        issue(1'b0, 18'h00099, 16'h0000, 16'h0000, 1'b1);
        issue(1'b0, 18'h00055, 16'h0000, 16'h1234, 1'b1);
        drain();

        check("ready_before_abort", {31'd0, ready}, 32'd1);
        req   = 1'b1;
        we    = 1'b1;
        addr  = 18'h00034;
        wdata = 16'hCAFE;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        check("abort_we_low", {31'd0, we_n}, 32'd0);
        #2 reset_n = 1'b0;
        #1;
        check("abort_we_n", {31'd0, we_n}, 32'd1);
        check("abort_ce_n", {31'd0, ce_n}, 32'd1);
        check("abort_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
        check("abort_rdata", {16'd0, rdata}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        issue(1'b0, 18'h00034, 16'h0000, 16'h0000, 1'b0);
        issue(1'b0, 18'h00012, 16'h0000, 16'hBEEF, 1'b1);
        drain();
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
